// File: rtl/pc_bd_pkg.sv
// Shared PC<->BD constants: field widths, per-leaf payload width table and chunk-count helper.
package pc_bd_pkg;

  localparam int NPCcode    = 7;
  localparam int NPCdata    = 20;
  localparam int Nleaf      = 32;
  localparam int Npayload   = 40;
  localparam int Nerr       = 16;

  localparam int LEAF_W     = $clog2(Nleaf);
  localparam int WIDTH_W    = 6;
  localparam int NCHUNK_MAX = Npayload / NPCdata;
  localparam int CHUNK_W    = $clog2(NCHUNK_MAX + 1);

  typedef logic [WIDTH_W-1:0] width_t;
  typedef logic [CHUNK_W-1:0] chunk_idx_t;
  typedef logic [LEAF_W-1:0]  leaf_t;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_ACCUM
  } state_t;

  // Payload width in bits of each leaf; every entry lies in 1..Npayload.
  localparam width_t LEAF_WIDTH [Nleaf] = '{
    6'd20, 6'd40, 6'd8,  6'd11, 6'd1,  6'd34, 6'd20, 6'd21,
    6'd16, 6'd24, 6'd32, 6'd12, 6'd40, 6'd2,  6'd19, 6'd39,
    6'd10, 6'd30, 6'd5,  6'd25, 6'd36, 6'd14, 6'd20, 6'd28,
    6'd3,  6'd40, 6'd22, 6'd17, 6'd9,  6'd33, 6'd6,  6'd38
  };

  function automatic chunk_idx_t n_chunks(input leaf_t leaf);
    int unsigned w;
    w = 32'(LEAF_WIDTH[leaf]);
    return chunk_idx_t'((w + NPCdata - 1) / NPCdata);
  endfunction

endpackage

// File: rtl/pc_chunk_accumulator.sv
// Payload accumulator: indexed chunk write, synchronous clear and masking above the leaf width.
module pc_chunk_accumulator
  import pc_bd_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic                 fresh,
  input  logic [CHUNK_W-1:0]   wr_idx,
  input  logic [NPCdata-1:0]   wr_data,
  input  logic [WIDTH_W-1:0]   width,
  output logic [Npayload-1:0]  word_next
);

  logic [Npayload-1:0] acc_reg;
  logic [Npayload-1:0] merged;
  logic [Npayload-1:0] width_mask;

  // A first chunk ignores whatever a discarded partial word left behind.
  for (genvar gi = 0; gi < NCHUNK_MAX; gi++) begin : g_chunk
    assign merged[gi*NPCdata +: NPCdata] =
      (wr_idx == chunk_idx_t'(gi)) ? wr_data :
      (fresh ? '0 : acc_reg[gi*NPCdata +: NPCdata]);
  end

  for (genvar gi = 0; gi < Npayload; gi++) begin : g_mask
    assign width_mask[gi] = (width > width_t'(gi));
  end

  assign word_next = merged & width_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
    end else if (wr_en) begin
      acc_reg <= word_next;
    end
  end

endmodule

// File: rtl/pc_word_deserializer.sv
// Reassembles LSB-first {code, data} PC chunks into full-width BD words tagged with their leaf.
module pc_word_deserializer
  import pc_bd_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NPCcode+NPCdata-1:0]  in_d,
  input  logic                        in_v,
  output logic                        in_a,
  output logic [NPCcode-1:0]          out_leaf,
  output logic [Npayload-1:0]         out_payload,
  output logic                        out_v,
  input  logic                        out_a,
  output logic                        err_pulse,
  output logic [Nerr-1:0]             err_count
);

  logic [NPCcode-1:0]  in_code;
  logic [NPCdata-1:0]  in_data;
  leaf_t               in_leaf;
  logic                code_legal;

  state_t              state_reg;
  leaf_t               cur_leaf_reg;
  chunk_idx_t          idx_reg;
  logic                out_v_reg;
  logic [NPCcode-1:0]  out_leaf_reg;
  logic [Npayload-1:0] out_payload_reg;
  logic                err_pulse_reg;
  logic [Nerr-1:0]     err_count_reg;

  logic                accept;
  logic                take_first;
  logic                take_cont;
  logic                word_done;
  logic                err_now;
  logic                acc_clear;
  chunk_idx_t          wr_idx;
  chunk_idx_t          in_nchunks;
  logic [Npayload-1:0] word_next;

  assign in_code    = in_d[NPCcode+NPCdata-1:NPCdata];
  assign in_data    = in_d[NPCdata-1:0];
  assign in_leaf    = in_code[LEAF_W-1:0];
  assign code_legal = (in_code[NPCcode-1:LEAF_W] == '0);

  assign in_a   = !out_v_reg || out_a;
  assign accept = in_v && in_a;

  always_comb begin
    take_first = accept && code_legal &&
                 ((state_reg == ST_IDLE) || (in_leaf != cur_leaf_reg));
    take_cont  = accept && code_legal &&
                 (state_reg == ST_ACCUM) && (in_leaf == cur_leaf_reg);
    wr_idx     = take_cont ? idx_reg : '0;
    in_nchunks = n_chunks(in_leaf);
    word_done  = (take_first || take_cont) &&
                 (wr_idx == (in_nchunks - chunk_idx_t'(1)));
    // An illegal code and a leaf switch in the same cycle are one error.
    err_now    = accept && (!code_legal ||
                 ((state_reg == ST_ACCUM) && (in_leaf != cur_leaf_reg)));
    acc_clear  = word_done || (accept && !code_legal);
  end

  pc_chunk_accumulator u_accum (
    .clk       (clk),
    .reset     (reset),
    .clear     (acc_clear),
    .wr_en     (take_first || take_cont),
    .fresh     (take_first),
    .wr_idx    (wr_idx),
    .wr_data   (in_data),
    .width     (LEAF_WIDTH[in_leaf]),
    .word_next (word_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      cur_leaf_reg    <= '0;
      idx_reg         <= '0;
      out_v_reg       <= 1'b0;
      out_leaf_reg    <= '0;
      out_payload_reg <= '0;
      err_pulse_reg   <= 1'b0;
      err_count_reg   <= '0;
    end else begin
      err_pulse_reg <= err_now;
      if (err_now && (err_count_reg != '1)) begin
        err_count_reg <= err_count_reg + Nerr'(1);
      end

      // A new word can only complete while the output is empty or draining.
      if (word_done) begin
        out_v_reg       <= 1'b1;
        out_leaf_reg    <= in_code;
        out_payload_reg <= word_next;
      end else if (out_a) begin
        out_v_reg <= 1'b0;
      end

      if ((accept && !code_legal) || word_done) begin
        state_reg <= ST_IDLE;
        idx_reg   <= '0;
      end else if (take_first) begin
        state_reg    <= ST_ACCUM;
        cur_leaf_reg <= in_leaf;
        idx_reg      <= chunk_idx_t'(1);
      end else if (take_cont) begin
        idx_reg <= idx_reg + chunk_idx_t'(1);
      end
    end
  end

  assign out_v       = out_v_reg;
  assign out_leaf    = out_leaf_reg;
  assign out_payload = out_payload_reg;
  assign err_pulse   = err_pulse_reg;
  assign err_count   = err_count_reg;

endmodule
